// File: rtl/adc_wire_window_mem.sv
// adc_wire_window_mem
// Memory-mapped ADC window for the wire module. Keeps a boxcar average per
// channel, maps one address window per channel plus one status word onto
// the CPU read bus, and latches debounced low-voltage wire-cut flags.
module adc_wire_window_mem #(
  parameter int                    NUM_CH     = 8,
  parameter int                    ADC_WIDTH  = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'he664,
  parameter logic [ADDR_WIDTH-1:0] WINDOW     = 16'h0222,
  parameter int                    AVG_LOG2   = 2,
  parameter logic [ADC_WIDTH-1:0]  CUT_THRESH = 12'h100,
  parameter int                    DEBOUNCE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q,
  input  logic                  smp_valid,
  input  logic [3:0]            smp_ch,
  input  logic [ADC_WIDTH-1:0]  smp_data,
  output logic [NUM_CH-1:0]     cut_mask,
  output logic                  cut_event
);

  // Accumulator holds exactly 2**AVG_LOG2 full-scale samples, so it never overflows.
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  // With AVG_LOG2 = 0 the count stays at 0 and every sample completes an average.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DBC_W = $clog2(DEBOUNCE + 1);
  // Window arithmetic carries one extra bit so a set ending exactly at 2**ADDR_WIDTH is exact.
  localparam int AW1   = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DBC_W-1:0] DBC_MAX    = DBC_W'(DEBOUNCE);
  localparam logic [AW1-1:0]   STATUS_OFF = AW1'(NUM_CH) * AW1'(WINDOW);
  localparam logic [AW1-1:0]   LAST_ADDR  = AW1'(BASE_ADDR) + STATUS_OFF;

  // The status word is the last mapped address; it must not wrap past the address space.
  if ((LAST_ADDR >= (AW1'(1) << ADDR_WIDTH)) || (NUM_CH < 1) || (NUM_CH > 16) ||
      (DATA_WIDTH < ADC_WIDTH) || (DATA_WIDTH < NUM_CH) || (DEBOUNCE < 1)) begin : g_bad_cfg
    $error("adc_wire_window_mem: invalid parameter set");
  end

  logic [ACC_W-1:0]     acc      [NUM_CH];
  logic [CNT_W-1:0]     cnt      [NUM_CH];
  logic [ADC_WIDTH-1:0] avg      [NUM_CH];
  logic [DBC_W-1:0]     dbc      [NUM_CH];

  logic [ACC_W-1:0]     acc_nx   [NUM_CH];
  logic [CNT_W-1:0]     cnt_nx   [NUM_CH];
  logic [ADC_WIDTH-1:0] avg_nx   [NUM_CH];
  logic [DBC_W-1:0]     dbc_nx   [NUM_CH];
  logic [NUM_CH-1:0]    mask_nx;
  logic [ACC_W-1:0]     sum;

  logic [AW1-1:0]        off;
  logic [DATA_WIDTH-1:0] rd_data;

  // Next-state for accumulation, averaging, debounce and cut latching.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    acc_nx  = acc;
    cnt_nx  = cnt;
    avg_nx  = avg;
    dbc_nx  = dbc;
    mask_nx = cut_mask;
    sum     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (smp_valid && (smp_ch == 4'(k))) begin
        sum = acc[k] + ACC_W'(smp_data);
        if (cnt[k] == CNT_LAST) begin
          acc_nx[k] = '0;
          cnt_nx[k] = '0;
          avg_nx[k] = ADC_WIDTH'(sum >> AVG_LOG2);
          if (avg_nx[k] < CUT_THRESH) begin
            if (dbc[k] != DBC_MAX) dbc_nx[k] = dbc[k] + DBC_W'(1);
            if (dbc_nx[k] == DBC_MAX) mask_nx[k] = 1'b1;
          end else begin
            dbc_nx[k] = '0;
          end
        end else begin
          acc_nx[k] = sum;
          cnt_nx[k] = cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Per-channel state registers; reset clears everything, including partial sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these small arrays are real registers that must start at 0, so they are reset explicitly.
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
        avg[k] <= '0;
        dbc[k] <= '0;
      end
      cut_mask  <= '0;
      cut_event <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      avg       <= avg_nx;
      dbc       <= dbc_nx;
      cut_mask  <= mask_nx;
      cut_event <= |(mask_nx & ~cut_mask);
    end
  end

  // Address decode against the current (pre-update) averages and mask.
  always_comb begin
    rd_data = '0;
    off     = AW1'(addr) - AW1'(BASE_ADDR);
    if (addr >= BASE_ADDR) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ((off >= AW1'(k) * AW1'(WINDOW)) && (off < AW1'(k + 1) * AW1'(WINDOW)))
          rd_data = DATA_WIDTH'(avg[k]);
      end
      if (off == STATUS_OFF) rd_data = DATA_WIDTH'(cut_mask);
    end
  end

  // Registered read port: q loads on en, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= rd_data;
  end

endmodule

// File: tb/tb_adc_wire_window_mem.sv
// tb_adc_wire_window_mem
// Directed bench with a sample-list behavioural model of averaging, cut
// detection and the address map, compared against the DUT every cycle.
module tb_adc_wire_window_mem;

  localparam int          NUM_CH   = 8;
  localparam int          AVG_N    = 4;
  localparam int          DEBOUNCE = 4;
  localparam int unsigned BASE     = 32'he664;
  localparam int unsigned WIN      = 32'h0222;
  localparam int unsigned THRESH   = 32'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] addr;
  logic [15:0] q;
  logic        smp_valid;
  logic [3:0]  smp_ch;
  logic [11:0] smp_data;
  logic [7:0]  cut_mask;
  logic        cut_event;

  int vectors = 0;
  int miscompares = 0;

  adc_wire_window_mem #(
    .NUM_CH(8), .ADC_WIDTH(12), .DATA_WIDTH(16), .ADDR_WIDTH(16),
    .BASE_ADDR(16'he664), .WINDOW(16'h0222), .AVG_LOG2(2),
    .CUT_THRESH(12'h100), .DEBOUNCE(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .q(q),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
    .cut_mask(cut_mask), .cut_event(cut_event)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned psum [NUM_CH];
  int          pcnt [NUM_CH];
  int unsigned m_avg[NUM_CH];
  int          m_run[NUM_CH];
  logic [7:0]  m_mask;
  logic [15:0] m_q;
  logic        m_event;
  bit          m_live = 1'b0;

  function automatic logic [15:0] model_read(input int unsigned a);
    int unsigned o;
    int unsigned k;
    if (a < BASE) return 16'h0;
    o = a - BASE;
    k = o / WIN;
    if (k < NUM_CH) return 16'(m_avg[k]);
    if (o == NUM_CH * WIN) return {8'h00, m_mask};
    return 16'h0;
  endfunction

  // Model advances on each rising edge from the inputs driven in the previous cycle.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        psum[k] = 0; pcnt[k] = 0; m_avg[k] = 0; m_run[k] = 0;
      end
      m_mask = '0; m_q = '0; m_event = 1'b0; m_live = 1'b1;
    end else begin
      if (en) m_q = model_read(32'(addr));
      m_event = 1'b0;
      if (smp_valid && smp_ch < NUM_CH) begin
        int k;
        k = int'(smp_ch);
        psum[k] += 32'(smp_data);
        pcnt[k]++;
        if (pcnt[k] == AVG_N) begin
          m_avg[k] = psum[k] / AVG_N;
          psum[k] = 0;
          pcnt[k] = 0;
          if (m_avg[k] < THRESH) m_run[k]++;
          else m_run[k] = 0;
          if (m_run[k] >= DEBOUNCE && !m_mask[k]) begin
            m_mask[k] = 1'b1;
            m_event = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: checks every output on every falling edge once the model is live.
  always @(negedge clk) begin
    if (m_live) begin
      check("q", 32'(q), 32'(m_q));
      check("cut_mask", 32'(cut_mask), 32'(m_mask));
      check("cut_event", 32'(cut_event), 32'(m_event));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] ch, input logic [11:0] d);
    smp_valid = 1'b1; smp_ch = ch; smp_data = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic avg4(input logic [3:0] ch, input logic [11:0] d);
    for (int i = 0; i < 4; i++) sample(ch, d);
  endtask

  task automatic rd(input logic [15:0] a);
    en = 1'b1; addr = a;
    tick();
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; addr = '0;
    smp_valid = 1'b0; smp_ch = '0; smp_data = '0;

    // 1. reset state
    tick(); tick();
    reset = 1'b0;
    rd(16'he664);
    check("reset_q", 32'(q), 32'h0);
    check("reset_mask", 32'(cut_mask), 32'h0);
    check("reset_event", 32'(cut_event), 32'h0);

    // 2. ch2 average and window boundary
    sample(4'd2, 12'd100); sample(4'd2, 12'd200);
    sample(4'd2, 12'd300); sample(4'd2, 12'd400);
    rd(16'heaa8);
    check("ch2_avg", 32'(q), 32'd250);
    rd(16'heaa7);
    check("ch1_last_addr", 32'(q), 32'd0);

    // 3. ch0 cut after four low averages
    for (int i = 0; i < 12; i++) sample(4'd0, 12'h050);
    check("ch0_no_cut_yet", 32'(cut_mask), 32'h00);
    for (int i = 0; i < 4; i++) sample(4'd0, 12'h050);
    check("ch0_cut_set", 32'(cut_mask), 32'h01);
    check("ch0_event", 32'(cut_event), 32'h1);
    tick();
    check("ch0_event_once", 32'(cut_event), 32'h0);
    rd(16'hf774);
    check("status_word", 32'(q), 32'h0001);
    rd(16'hf775);
    check("past_status", 32'(q), 32'h0);
    rd(16'hf552);
    check("ch7_window", 32'(q), 32'h0);

    // 4. ch5 debounce restart then cut, sticky under high averages
    avg4(4'd5, 12'h010); avg4(4'd5, 12'h010); avg4(4'd5, 12'h010);
    avg4(4'd5, 12'h200);
    avg4(4'd5, 12'h010); avg4(4'd5, 12'h010); avg4(4'd5, 12'h010);
    check("ch5_no_cut", 32'(cut_mask), 32'h01);
    avg4(4'd5, 12'h010);
    check("ch5_cut", 32'(cut_mask), 32'h21);
    avg4(4'd5, 12'hfff); avg4(4'd5, 12'hfff);
    check("ch5_sticky", 32'(cut_mask), 32'h21);
    rd(16'hf10e);
    check("ch5_full_scale", 32'(q), 32'h0fff);

    // 5. edge cases
    sample(4'd9, 12'h001);
    check("bad_ch_mask", 32'(cut_mask), 32'h21);
    rd(16'heaa8);
    check("ch2_reread", 32'(q), 32'd250);
    addr = 16'h0000; tick();
    check("en0_hold_a", 32'(q), 32'd250);
    addr = 16'hf774; tick();
    check("en0_hold_b", 32'(q), 32'd250);
    rd(16'h0000);
    check("below_base", 32'(q), 32'h0);

    // 6. reset mid-average, with a sample in the reset cycle
    sample(4'd3, 12'h800); sample(4'd3, 12'h800);
    reset = 1'b1; smp_valid = 1'b1; smp_ch = 4'd3; smp_data = 12'h800;
    tick();
    reset = 1'b0; smp_valid = 1'b0;
    check("post_reset_mask", 32'(cut_mask), 32'h0);
    check("post_reset_q", 32'(q), 32'h0);
    avg4(4'd3, 12'd40);
    rd(16'hecca);
    check("ch3_clean_avg", 32'(q), 32'd40);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
